time_ctrl: RTL and testbench



---
 rtl/time_pkg.sv | 39 +++
 rtl/time_field_inc.sv | 41 ++++
 rtl/time_ctrl.sv | 142 ++++++++++++++
 tb/tb_time_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared constants for the clock display mode/edit path.
// Packing: {h10, h[3:0], m10[2:0], m[3:0], s10[2:0], s[3:0]}.
package time_pkg;

    localparam int TW = 19;

    typedef enum logic [1:0] {
        MODE_PRESENT = 2'b00,
        MODE_TSET    = 2'b01,
        MODE_ASET    = 2'b10
    } mode_e;

    localparam logic [2:0] SEL_S   = 3'd0;
    localparam logic [2:0] SEL_S10 = 3'd1;
    localparam logic [2:0] SEL_M   = 3'd2;
    localparam logic [2:0] SEL_M10 = 3'd3;
    localparam logic [2:0] SEL_H   = 3'd4;
    localparam logic [2:0] SEL_H10 = 3'd5;

    localparam int S_LSB   = 0;
    localparam int S10_LSB = 4;
    localparam int M_LSB   = 7;
    localparam int M10_LSB = 11;
    localparam int H_LSB   = 14;
    localparam int H10_LSB = 18;

    localparam logic [3:0] MAX_S    = 4'd9;
    localparam logic [2:0] MAX_S10  = 3'd5;
    localparam logic [3:0] MAX_M    = 4'd9;
    localparam logic [2:0] MAX_M10  = 3'd5;
    localparam logic [3:0] MAX_H_12 = 4'd2;
    localparam logic [3:0] MAX_H_09 = 4'd9;
    localparam logic       MAX_H10  = 1'b1;

    function automatic logic [2:0] sel_next(input logic [2:0] s);
        return (s >= SEL_H10) ? SEL_S : s + 3'd1;
    endfunction

endpackage

// File: rtl/time_field_inc.sv
// Increments one BCD field of a packed time value with per-field wrap.
module time_field_inc
    import time_pkg::*;
(
    input  logic [TW-1:0] val_i,
    input  logic [2:0]    sel_i,
    output logic [TW-1:0] val_o
);

    logic [3:0] s, m, h, h_max;
    logic [2:0] s10, m10;
    logic       h10;

    assign s   = val_i[S_LSB +: 4];
    assign s10 = val_i[S10_LSB +: 3];
    assign m   = val_i[M_LSB +: 4];
    assign m10 = val_i[M10_LSB +: 3];
    assign h   = val_i[H_LSB +: 4];
    assign h10 = val_i[H10_LSB];

    // Hour units range depends on the tens digit (00-12 clock)
    assign h_max = h10 ? MAX_H_12 : MAX_H_09;

    always_comb begin
        val_o = val_i;
        case (sel_i)
            SEL_S:   val_o[S_LSB +: 4]   = (s >= MAX_S) ? 4'd0 : s + 4'd1;
            SEL_S10: val_o[S10_LSB +: 3] = (s10 >= MAX_S10) ? 3'd0 : s10 + 3'd1;
            SEL_M:   val_o[M_LSB +: 4]   = (m >= MAX_M) ? 4'd0 : m + 4'd1;
            SEL_M10: val_o[M10_LSB +: 3] = (m10 >= MAX_M10) ? 3'd0 : m10 + 3'd1;
            SEL_H:   val_o[H_LSB +: 4]   = (h >= h_max) ? 4'd0 : h + 4'd1;
            SEL_H10: begin
                val_o[H10_LSB] = (h10 == MAX_H10) ? 1'b0 : 1'b1;
                if (!h10 && h > MAX_H_12)
                    val_o[H_LSB +: 4] = MAX_H_12;
            end
            default: val_o = val_i;
        endcase
    end

endmodule

// File: rtl/time_ctrl.sv
// Mode/edit sequencer: mode FSM, digit select, set registers,
// blink generator, timekeeper load pulse and alarm match.
module time_ctrl
    import time_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn_mode,
    input  logic          btn_sel,
    input  logic          btn_up,
    input  logic          sec_tick,
    input  logic [TW-1:0] present_time,
    output logic [1:0]    state,
    output logic [2:0]    s_state,
    output logic [2:0]    s_state2,
    output logic [TW-1:0] timeset,
    output logic [TW-1:0] al_time,
    output logic          time_load,
    output logic          blink,
    output logic          alarm_on
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_HALF - 1);

    mode_e          state_q, state_d;
    logic [2:0]     sel_t_q, sel_t_d, sel_a_q, sel_a_d;
    logic [TW-1:0]  ts_q, ts_d, al_q, al_d;
    logic           load_q, load_d, blink_q, blink_d, alarm_q, alarm_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           enter_tset, enter_aset, in_tset, in_aset;
    logic           sel_p, up_p, accept;
    logic [TW-1:0]  inc_in, inc_out;
    logic [2:0]     inc_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MODE_PRESENT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_PRESENT: if (btn_mode) state_d = MODE_TSET;
            MODE_TSET:    if (btn_mode) state_d = MODE_ASET;
            MODE_ASET:    if (btn_mode) state_d = MODE_PRESENT;
            default:      state_d = MODE_PRESENT;
        endcase
    end

    always_comb begin
        in_tset    = (state_q == MODE_TSET);
        in_aset    = (state_q == MODE_ASET);
        enter_tset = !in_tset && (state_d == MODE_TSET);
        enter_aset = !in_aset && (state_d == MODE_ASET);
        load_d     = in_tset && (state_d == MODE_ASET);
    end

    // One action per cycle: mode beats sel beats up
    assign sel_p  = btn_sel & ~btn_mode;
    assign up_p   = btn_up & ~btn_mode & ~btn_sel;
    assign accept = (in_tset | in_aset) & (sel_p | up_p);

    assign inc_in  = in_aset ? al_q : ts_q;
    assign inc_sel = in_aset ? sel_a_q : sel_t_q;

    time_field_inc u_inc (
        .val_i (inc_in),
        .sel_i (inc_sel),
        .val_o (inc_out)
    );

    always_comb begin
        ts_d    = ts_q;
        al_d    = al_q;
        sel_t_d = sel_t_q;
        sel_a_d = sel_a_q;
        if (enter_tset) begin
            ts_d    = present_time;
            sel_t_d = SEL_S;
        end
        if (enter_aset) sel_a_d = SEL_S;
        if (in_tset && sel_p) sel_t_d = sel_next(sel_t_q);
        if (in_aset && sel_p) sel_a_d = sel_next(sel_a_q);
        if (in_tset && up_p)  ts_d = inc_out;
        if (in_aset && up_p)  al_d = inc_out;
    end

    always_comb begin
        blink_d = blink_q;
        cnt_d   = cnt_q + CW'(1);
        if (accept) begin
            blink_d = 1'b1;
            cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
            blink_d = ~blink_q;
            cnt_d   = '0;
        end
    end

    always_comb begin
        alarm_d = alarm_q;
        if (btn_mode | btn_sel | btn_up)
            alarm_d = 1'b0;
        else if (sec_tick && state_q == MODE_PRESENT && present_time == al_q)
            alarm_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_t_q <= SEL_S;
            sel_a_q <= SEL_S;
            ts_q    <= '0;
            al_q    <= '0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            sel_t_q <= sel_t_d;
            sel_a_q <= sel_a_d;
            ts_q    <= ts_d;
            al_q    <= al_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign state     = state_q;
    assign s_state   = sel_t_q;
    assign s_state2  = sel_a_q;
    assign timeset   = ts_q;
    assign al_time   = al_q;
    assign time_load = load_q;
    assign blink     = blink_q;
    assign alarm_on  = alarm_q;

endmodule

// File: tb/tb_time_ctrl.sv
// Bench for time_ctrl: digit-array reference model checked every cycle
// plus directed literal expectations.
module tb_time_ctrl;

    localparam int BH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_mode = 0, btn_sel = 0, btn_up = 0, sec_tick = 0;
    logic [18:0] present_time = '0;
    logic [1:0]  state;
    logic [2:0]  s_state, s_state2;
    logic [18:0] timeset, al_time;
    logic        time_load, blink, alarm_on;

    time_ctrl #(.BLINK_HALF(BH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode     (btn_mode),
        .btn_sel      (btn_sel),
        .btn_up       (btn_up),
        .sec_tick     (sec_tick),
        .present_time (present_time),
        .state        (state),
        .s_state      (s_state),
        .s_state2     (s_state2),
        .timeset      (timeset),
        .al_time      (al_time),
        .time_load    (time_load),
        .blink        (blink),
        .alarm_on     (alarm_on)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state
    int          md, st, sa, mcnt;
    logic [18:0] mts, mal;
    bit          mtl, mbl, malm;

    function automatic logic [18:0] pk(int h10, int h, int m10, int m,
                                       int s10, int s);
        return {1'(h10), 4'(h), 3'(m10), 4'(m), 3'(s10), 4'(s)};
    endfunction

    function automatic logic [18:0] m_inc(logic [18:0] v, int f);
        int d[6];
        int mx;
        d[0] = int'(v[3:0]);
        d[1] = int'(v[6:4]);
        d[2] = int'(v[10:7]);
        d[3] = int'(v[13:11]);
        d[4] = int'(v[17:14]);
        d[5] = int'(v[18]);
        case (f)
            0, 2:    mx = 9;
            1, 3:    mx = 5;
            4:       mx = (d[5] == 1) ? 2 : 9;
            default: mx = 1;
        endcase
        if (f == 5) begin
            d[5] = 1 - d[5];
            if (d[5] == 1 && d[4] > 2) d[4] = 2;
        end else begin
            d[f] = (d[f] >= mx) ? 0 : d[f] + 1;
        end
        return pk(d[5], d[4], d[3], d[2], d[1], d[0]);
    endfunction

    task automatic model_reset();
        md = 0; st = 0; sa = 0; mcnt = 0;
        mts = '0; mal = '0;
        mtl = 0; mbl = 0; malm = 0;
    endtask

    task automatic model_step();
        bit acc, set, tl;
        acc = 0;
        tl = 0;
        set = sec_tick && md == 0 && present_time == mal;
        if (btn_mode) begin
            if (md == 1) tl = 1;
            md = (md + 1) % 3;
            if (md == 1) begin mts = present_time; st = 0; end
            if (md == 2) sa = 0;
        end else if (btn_sel && md != 0) begin
            acc = 1;
            if (md == 1) st = (st + 1) % 6;
            else         sa = (sa + 1) % 6;
        end else if (btn_up && md != 0) begin
            acc = 1;
            if (md == 1) mts = m_inc(mts, st);
            else         mal = m_inc(mal, sa);
        end
        mtl = tl;
        if (acc) begin
            mbl = 1; mcnt = 0;
        end else if (mcnt == BH - 1) begin
            mbl = ~mbl; mcnt = 0;
        end else begin
            mcnt++;
        end
        if (btn_mode | btn_sel | btn_up) malm = 0;
        else if (set)                    malm = 1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_state",    32'(state),     32'(md));
            check("m_s_state",  32'(s_state),   32'(st));
            check("m_s_state2", 32'(s_state2),  32'(sa));
            check("m_timeset",  32'(timeset),   32'(mts));
            check("m_al_time",  32'(al_time),   32'(mal));
            check("m_load",     32'(time_load), 32'(mtl));
            check("m_blink",    32'(blink),     32'(mbl));
            check("m_alarm",    32'(alarm_on),  32'(malm));
        end
    end

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            @(negedge clk);
        end
    endtask

    task automatic p_mode(); btn_mode = 1; cyc(); btn_mode = 0; endtask
    task automatic p_sel();  btn_sel = 1;  cyc(); btn_sel = 0;  endtask
    task automatic p_up();   btn_up = 1;   cyc(); btn_up = 0;   endtask

    initial begin
        model_reset();
        #2 rst_n = 0;
        #1;
        chk_en = 1;
        cyc(2);
        rst_n = 1;
        check("rst_state", 32'(state), 0);
        check("rst_timeset", 32'(timeset), 0);
        check("rst_blink", 32'(blink), 0);

        // Mode cycle and time_load with captured 11:59:58
        present_time = pk(1, 1, 5, 9, 5, 8);
        p_mode();
        check("tset_state", 32'(state), 1);
        check("tset_capture", 32'(timeset), 32'(pk(1, 1, 5, 9, 5, 8)));
        p_mode();
        check("aset_state", 32'(state), 2);
        check("load_pulse", 32'(time_load), 1);
        check("load_ts", 32'(timeset), 32'(pk(1, 1, 5, 9, 5, 8)));
        cyc();
        check("load_gone", 32'(time_load), 0);
        p_mode();
        check("present_state", 32'(state), 0);

        // Field wraps in TSET from 07:34:49
        present_time = pk(0, 7, 3, 4, 4, 9);
        p_mode();
        p_up();
        check("s_wrap", 32'(timeset), 32'(pk(0, 7, 3, 4, 4, 0)));
        p_sel();
        p_up();
        p_up();
        check("s10_wrap", 32'(timeset), 32'(pk(0, 7, 3, 4, 0, 0)));
        repeat (4) p_sel();
        check("sel_h10", 32'(s_state), 5);
        p_up();
        check("h10_clamp", 32'(timeset), 32'(pk(1, 2, 3, 4, 0, 0)));
        repeat (5) p_sel();
        check("sel_h", 32'(s_state), 4);
        p_up();
        check("h_wrap0", 32'(timeset), 32'(pk(1, 0, 3, 4, 0, 0)));
        p_up();
        p_up();
        check("h_two", 32'(timeset), 32'(pk(1, 2, 3, 4, 0, 0)));

        // Mode wins over simultaneous up
        btn_mode = 1; btn_up = 1;
        cyc();
        btn_mode = 0; btn_up = 0;
        check("prio_state", 32'(state), 2);
        check("prio_ts", 32'(timeset), 32'(pk(1, 2, 3, 4, 0, 0)));
        check("prio_load", 32'(time_load), 1);
        repeat (5) p_sel();
        check("sel2_5", 32'(s_state2), 5);
        p_sel();
        check("sel2_wrap", 32'(s_state2), 0);

        // Blink restart on edit
        cyc(2);
        p_up();
        check("blink_force", 32'(blink), 1);
        cyc(3);
        check("blink_hold", 32'(blink), 1);
        cyc();
        check("blink_toggle", 32'(blink), 0);
        cyc(4);
        check("blink_toggle2", 32'(blink), 1);

        // Alarm match at 00:00:05
        repeat (4) p_up();
        check("al_set", 32'(al_time), 32'(pk(0, 0, 0, 0, 0, 5)));
        p_mode();
        present_time = pk(0, 0, 0, 0, 0, 5);
        sec_tick = 1; cyc(); sec_tick = 0;
        check("alarm_set", 32'(alarm_on), 1);
        p_sel();
        check("alarm_clr", 32'(alarm_on), 0);
        check("sel_ignored", 32'(state), 0);
        sec_tick = 1; btn_up = 1; cyc(); sec_tick = 0; btn_up = 0;
        check("clr_wins", 32'(alarm_on), 0);
        p_mode();
        sec_tick = 1; cyc(); sec_tick = 0;
        check("alarm_tset", 32'(alarm_on), 0);

        // Asynchronous reset mid-edit
        p_up();
        cyc(2);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_ts", 32'(timeset), 0);
        check("arst_load", 32'(time_load), 0);
        cyc(2);
        rst_n = 1;
        cyc(3);
        check("post_rst_load", 32'(time_load), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
